// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
// Round-robin burst-read controller sitting in front of a single 64x8
// synchronous ROM. Two requesters post (addr, len) bursts. The winner's
// burst is issued as consecutive incrementing ROM reads that wrap at the
// top of the address space. Read data comes back tagged with the owner's
// id and an end-of-burst marker.

module rom_burst_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          grant0,
  output logic          grant1,
  output logic          busy,
  output logic          rom_en,
  output logic [AW-1:0] rom_add,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          rid,
  output logic          rlast
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state;
  logic          last_id;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] remaining;
  logic          id;
  logic          pick_any;
  logic          pick_id;

  // Arbitration: a lone request wins outright; on a tie the requester
  // that was not served most recently goes next.
  always_comb begin
    pick_any = req0 | req1;
    pick_id  = 1'b0;
    if (req0 && req1) begin
      pick_id = ~last_id;
    end else begin
      pick_id = req1;
    end
  end

  // Control state, burst sequencing, grant pulses and the one-cycle
  // delayed return-path markers that line up with the ROM's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      cur_addr  <= '0;
      remaining <= '0;
      id        <= 1'b0;
      grant0    <= 1'b0;
      grant1    <= 1'b0;
      rvalid    <= 1'b0;
      rid       <= 1'b0;
      rlast     <= 1'b0;
    end else begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      rvalid <= (state == BURST);
      rid    <= id;
      rlast  <= (state == BURST) && (remaining == '0);
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BURST;
            id        <= pick_id;
            last_id   <= pick_id;
            cur_addr  <= pick_id ? addr1 : addr0;
            remaining <= pick_id ? len1 : len0;
            grant0    <= ~pick_id;
            grant1    <= pick_id;
          end
        end
        BURST: begin
          cur_addr  <= cur_addr + AW'(1);
          remaining <= remaining - LW'(1);
          if (remaining == '0) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == BURST);
  assign rom_en  = (state == BURST);
  assign rom_add = cur_addr;
  assign rdata   = rom_data;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter
// Scoreboard bench: two requester drivers post bursts, a transaction-level
// reference model predicts grants and returned beats into queues, and a
// monitor pops and compares whenever the DUT presents a grant or a beat.

module tb_rom_burst_arbiter;

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       lst;
    int         cyc;
  } beat_t;

  typedef struct {
    logic id;
    int   cyc;
  } grant_t;

  typedef struct {
    logic [5:0] addr;
    logic [3:0] len;
  } req_t;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [5:0] addr0, addr1;
  logic [3:0] len0, len1;
  logic       grant0, grant1, busy, rom_en, rvalid, rid, rlast;
  logic [5:0] rom_add;
  logic [7:0] rom_data, rdata;

  logic       reqv[2];
  logic [5:0] addrv[2];
  logic [3:0] lenv[2];
  logic       active[2];
  int         waitc[2];

  logic [7:0] mem[64];
  beat_t      beatQ[$];
  grant_t     grantQ[$];
  req_t       pend0[$];
  req_t       pend1[$];

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int nextFree = 0;
  int burstStart = 1;
  int burstEnd = 0;
  int burstAddr = 0;
  logic lastServed = 1'b1;

  assign req0  = reqv[0];
  assign req1  = reqv[1];
  assign addr0 = addrv[0];
  assign addr1 = addrv[1];
  assign len0  = lenv[0];
  assign len1  = lenv[1];

  rom_burst_arbiter #(.AW(6), .DW(8), .LW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1),
    .grant0(grant0), .grant1(grant1),
    .busy(busy), .rom_en(rom_en), .rom_add(rom_add),
    .rom_data(rom_data), .rdata(rdata),
    .rvalid(rvalid), .rid(rid), .rlast(rlast)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Standard ROM image and its registered, enable-gated read port.
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = (i <= 15) ? 8'(i) : 8'(mem[i-1] + 8'd2);
    end
    rom_data = 8'h00;
  end

  always @(posedge clk) begin
    rom_data <= rom_en ? mem[rom_add] : 8'h00;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, expected, cnt);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s %s at cycle %0d", name, detail, cnt);
  endtask

  task automatic applyStimulus(input int r, input int addr, input int len);
    req_t t;
    t.addr = 6'(addr);
    t.len  = 4'(len);
    if (r == 0) pend0.push_back(t);
    else        pend1.push_back(t);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_grant0", grant0, 0);
    checkOutput("rst_grant1", grant1, 0);
    checkOutput("rst_busy",   busy,   0);
    checkOutput("rst_rom_en", rom_en, 0);
    checkOutput("rst_rom_add", rom_add, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rid",    rid,    0);
    checkOutput("rst_rlast",  rlast,  0);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || active[0] || active[1] ||
            beatQ.size() != 0 || grantQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      reportFail("idle_timeout", $sformatf("actual=beats_left %0d required=0", beatQ.size()));
      beatQ.delete();
      grantQ.delete();
    end
    @(negedge clk);
  endtask

  // Reference model: a burst sampled at edge E of an idle controller
  // produces a grant in cycle E, ROM reads in cycles E..E+len, beats in
  // cycles E+1..E+len+1, and the next request can be sampled at E+len+2.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beatQ.delete();
      grantQ.delete();
      lastServed = 1'b1;
      nextFree   = 0;
      burstStart = 1;
      burstEnd   = 0;
    end else begin
      cnt++;
      if (cnt >= nextFree && (reqv[0] || reqv[1])) begin
        int w;
        int a;
        int l;
        grant_t g;
        if (reqv[0] && reqv[1]) w = lastServed ? 0 : 1;
        else                    w = reqv[1] ? 1 : 0;
        a = int'(addrv[w]);
        l = int'(lenv[w]);
        g.id  = w[0];
        g.cyc = cnt;
        grantQ.push_back(g);
        for (int k = 0; k <= l; k++) begin
          beat_t b;
          b.id   = w[0];
          b.data = mem[(a + k) % 64];
          b.lst  = (k == l);
          b.cyc  = cnt + 1 + k;
          beatQ.push_back(b);
        end
        burstStart = cnt;
        burstEnd   = cnt + l;
        burstAddr  = a;
        nextFree   = cnt + l + 2;
        lastServed = w[0];
      end
    end
  end

  // Monitor: pops expectations when the DUT shows a grant or beat, and
  // tracks the ROM port against the model's active burst window.
  always @(negedge clk) begin
    if (!rst) begin
      logic expEn;
      if (grantQ.size() != 0 && grantQ[0].cyc < cnt) begin
        reportFail("grant_missed", $sformatf("actual=none required=grant%0d", grantQ[0].id));
        void'(grantQ.pop_front());
      end
      if (grant0 || grant1) begin
        if (grantQ.size() == 0) begin
          reportFail("grant_unexpected", $sformatf("actual=g0:%0d g1:%0d required=none", grant0, grant1));
        end else begin
          grant_t g;
          g = grantQ.pop_front();
          checkOutput("grant_both", grant0 & grant1, 0);
          checkOutput("grant_id", grant1, g.id);
          checkOutput("grant_cycle", cnt, g.cyc);
        end
      end
      if (beatQ.size() != 0 && beatQ[0].cyc < cnt) begin
        reportFail("beat_missed", $sformatf("actual=none required=%0h", beatQ[0].data));
        void'(beatQ.pop_front());
      end
      if (rvalid) begin
        if (beatQ.size() == 0) begin
          reportFail("beat_unexpected", $sformatf("actual=%0h required=none", rdata));
        end else begin
          beat_t b;
          b = beatQ.pop_front();
          checkOutput("rdata", rdata, b.data);
          checkOutput("rid", rid, b.id);
          checkOutput("rlast", rlast, b.lst);
          checkOutput("beat_cycle", cnt, b.cyc);
        end
      end else begin
        checkOutput("rlast_idle", rlast, 0);
      end
      expEn = (cnt >= burstStart) && (cnt <= burstEnd);
      checkOutput("rom_en", rom_en, expEn);
      checkOutput("busy", busy, expEn);
      if (expEn) begin
        checkOutput("rom_add", rom_add, (burstAddr + (cnt - burstStart)) % 64);
      end
    end
  end

  // Requester drivers: raise req with the next pending burst, hold it
  // until the grant pulse, then drop it. Reset abandons any outstanding one.
  initial begin
    logic g;
    req_t t;
    for (int r = 0; r < 2; r++) begin
      reqv[r] = 1'b0; addrv[r] = '0; lenv[r] = '0; active[r] = 1'b0; waitc[r] = 0;
    end
    forever begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        g = (r == 0) ? grant0 : grant1;
        if (rst) begin
          reqv[r]   = 1'b0;
          active[r] = 1'b0;
        end else if (active[r]) begin
          if (g) begin
            reqv[r]   = 1'b0;
            active[r] = 1'b0;
          end else begin
            waitc[r]++;
            if (waitc[r] > 100) begin
              reportFail("grant_timeout", $sformatf("actual=no_grant required=grant%0d", r));
              reqv[r]   = 1'b0;
              active[r] = 1'b0;
            end
          end
        end else if ((r == 0 && pend0.size() != 0) || (r == 1 && pend1.size() != 0)) begin
          t = (r == 0) ? pend0.pop_front() : pend1.pop_front();
          addrv[r]  = t.addr;
          lenv[r]   = t.len;
          reqv[r]   = 1'b1;
          active[r] = 1'b1;
          waitc[r]  = 0;
        end
      end
    end
  end

  // Directed scenarios followed by a randomized run and a mid-burst reset.
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs();
    rst = 1'b0;

    applyStimulus(0, 5, 1);
    applyStimulus(1, 20, 0);
    waitIdle(200);

    applyStimulus(0, 14, 3);
    waitIdle(200);

    applyStimulus(1, 62, 2);
    waitIdle(200);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i * 3, 0);
      applyStimulus(1, 40 + i, 0);
    end
    waitIdle(300);

    applyStimulus(0, 0, 15);
    repeat (5) @(negedge clk);
    applyStimulus(1, 30, 1);
    waitIdle(300);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) waitIdle(2000);
    end
    waitIdle(3000);

    applyStimulus(0, 0, 15);
    n = 0;
    while (!grant0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      reportFail("reset_burst_grant", "actual=no_grant required=grant0");
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs();
    @(negedge clk);
    checkResetOutputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_rvalid", rvalid, 0);
    checkOutput("post_rst_rom_en", rom_en, 0);

    applyStimulus(1, 10, 4);
    waitIdle(200);
    checkOutput("beatq_drained", beatQ.size(), 0);
    checkOutput("grantq_drained", grantQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
